// File: rtl/cla_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_if
// Description : Operand/result handshake bundle for the pipelined CLA
//               adder/subtractor. The slave side is the adder; the master
//               side is the ALU sequencer / downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cla_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             out_ready_in;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_carry;
  logic             in_sub;
  logic             out_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;
  logic             out_negative;

  modport slave (
    input  in_valid, in_x, in_y, in_carry, in_sub, in_ready,
    output out_ready_in, out_valid, out_sum, out_carry, out_overflow,
           out_zero, out_negative
  );

  modport master (
    output in_valid, in_x, in_y, in_carry, in_sub, in_ready,
    input  out_ready_in, out_valid, out_sum, out_carry, out_overflow,
           out_zero, out_negative
  );
endinterface
`default_nettype wire

// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe
// Description : Pipelined carry-lookahead adder/subtractor. One SEG-bit
//               segment is resolved per stage using 4-bit lookahead groups
//               and a second-level group lookahead; the segment carry is
//               registered into the next stage. Global-stall valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe #(
  parameter int WIDTH = 32,  // multiple of SEG
  parameter int SEG   = 8    // multiple of 4
) (
  input  logic          in_clk,
  input  logic          in_reset,
  cla_pipe_if.slave     bus
);
  localparam int STAGES = WIDTH / SEG;
  localparam int GROUPS = SEG / 4;

  // Two-level lookahead add of one segment: returns {carry_out, sum}.
  // Every carry is a flat sum-of-products of generate/propagate terms.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0]    g, p, c;
    logic [GROUPS-1:0] gg, gp;
    logic [GROUPS:0]   gc;
    logic              t;
    g = a & b;
    p = a ^ b;
    // Group generate / propagate for each 4-bit group
    for (int j = 0; j < GROUPS; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = g[4*j+i];
        for (int l = i + 1; l < 4; l++) t = t & p[4*j+l];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[4*j+i];
      end
    end
    // Second level: carry into each group straight from group G/P and cin
    for (int j = 0; j <= GROUPS; j++) begin
      t = cin;
      for (int l = 0; l < j; l++) t = t & gp[l];
      gc[j] = t;
      for (int m = 0; m < j; m++) begin
        t = gg[m];
        for (int l = m + 1; l < j; l++) t = t & gp[l];
        gc[j] = gc[j] | t;
      end
    end
    // Bit carries inside each group from that group's carry-in
    for (int j = 0; j < GROUPS; j++) begin
      for (int i = 0; i < 4; i++) begin
        t = gc[j];
        for (int l = 0; l < i; l++) t = t & p[4*j+l];
        c[4*j+i] = t;
        for (int m = 0; m < i; m++) begin
          t = g[4*j+m];
          for (int l = m + 1; l < i; l++) t = t & p[4*j+l];
          c[4*j+i] = c[4*j+i] | t;
        end
      end
    end
    return {gc[GROUPS], p ^ c};
  endfunction

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] y_eff;
  logic             c0;

  assign advance          = ~bus.out_valid | bus.in_ready;
  assign accept           = bus.in_valid & advance;
  assign bus.out_ready_in = advance;
  assign y_eff            = bus.in_sub ? ~bus.in_y : bus.in_y;
  assign c0               = bus.in_sub | bus.in_carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG - 1;

    logic [SEG-1:0] op_a, op_b;
    logic           cin, vin;
    logic [SEG:0]   r;
    logic [HI:0]    s_d, s_q;
    logic           v_d, v_q, c_d, c_q;

    assign r = seg_add(op_a, op_b, cin);

    if (k == 0) begin : g_head
      assign op_a = bus.in_x[SEG-1:0];
      assign op_b = y_eff[SEG-1:0];
      assign cin  = c0;
      assign vin  = accept;
      assign s_d  = r[SEG-1:0];
    end else begin : g_body
      assign op_a = g_stage[k-1].g_fwd.x_q[HI:LO];
      assign op_b = g_stage[k-1].g_fwd.y_q[HI:LO];
      assign cin  = g_stage[k-1].c_q;
      assign vin  = g_stage[k-1].v_q;
      assign s_d  = {r[SEG-1:0], g_stage[k-1].s_q};
    end

    // Next-state for the stage valid bit and the segment carry
    always_comb begin
      v_d = vin;
      c_d = r[SEG];
    end

    // Stage register: cleared on reset, frozen while stalled
    always_ff @(posedge in_clk) begin
      if (in_reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    // Unresolved upper segments of X and Y' ride along until their stage
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI+1] x_d, x_q, y_d, y_q;

      if (k == 0) begin : g_src_in
        assign x_d = bus.in_x[WIDTH-1:HI+1];
        assign y_d = y_eff[WIDTH-1:HI+1];
      end else begin : g_src_prev
        assign x_d = g_stage[k-1].g_fwd.x_q[WIDTH-1:HI+1];
        assign y_d = g_stage[k-1].g_fwd.y_q[WIDTH-1:HI+1];
      end

      // Operand skew registers, held with the rest of the stage
      always_ff @(posedge in_clk) begin
        if (in_reset) begin
          x_q <= '0;
          y_q <= '0;
        end else if (advance) begin
          x_q <= x_d;
          y_q <= y_d;
        end
      end
    end

    // Final stage derives the flags from the completed result
    if (k == STAGES - 1) begin : g_flags
      logic ovf_d, ovf_q, zero_d, zero_q, neg_d, neg_q;

      // Carry into the MSB equals a^b^sum at the MSB, so this is cin_msb ^ cout
      always_comb begin
        ovf_d  = op_a[SEG-1] ^ op_b[SEG-1] ^ r[SEG-1] ^ r[SEG];
        zero_d = ~|s_d;
        neg_d  = s_d[HI];
      end

      // Flag registers share reset and stall behaviour with the result
      always_ff @(posedge in_clk) begin
        if (in_reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (advance) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
          neg_q  <= neg_d;
        end
      end
    end
  end

  assign bus.out_valid    = g_stage[STAGES-1].v_q;
  assign bus.out_sum      = g_stage[STAGES-1].s_q;
  assign bus.out_carry    = g_stage[STAGES-1].c_q;
  assign bus.out_overflow = g_stage[STAGES-1].g_flags.ovf_q;
  assign bus.out_zero     = g_stage[STAGES-1].g_flags.zero_q;
  assign bus.out_negative = g_stage[STAGES-1].g_flags.neg_q;
endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe
// Description : Self-checking bench for cla_pipe (32/8, 16/4 and 64/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_pipe_if #(.WIDTH(32)) b32 ();
  cla_pipe_if #(.WIDTH(16)) b16 ();
  cla_pipe_if #(.WIDTH(64)) b64 ();

  cla_pipe #(.WIDTH(32), .SEG(8))  dut   (.in_clk(clk), .in_reset(rst), .bus(b32));
  cla_pipe #(.WIDTH(16), .SEG(4))  dut16 (.in_clk(clk), .in_reset(rst), .bus(b16));
  cla_pipe #(.WIDTH(64), .SEG(16)) dut64 (.in_clk(clk), .in_reset(rst), .bus(b64));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] x, y;
    logic        ci, sub;
    logic [31:0] s;
    logic        c, v, z, n;
  } vec_t;
  vec_t vecs[11];

  // Independent arithmetic reference: {carry, overflow, zero, negative, sum}
  function automatic logic [19:0] ref16(logic [15:0] x, logic [15:0] y, logic ci, logic sub);
    logic [16:0] s; logic [15:0] r; logic c, v;
    if (sub) begin
      r = x - y; c = (x >= y); v = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      s = {1'b0, x} + {1'b0, y} + {16'b0, ci};
      r = s[15:0]; c = s[16]; v = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {c, v, (r == 16'd0), r[15], r};
  endfunction

  function automatic logic [67:0] ref64(logic [63:0] x, logic [63:0] y, logic ci, logic sub);
    logic [64:0] s; logic [63:0] r; logic c, v;
    if (sub) begin
      r = x - y; c = (x >= y); v = (x[63] != y[63]) && (r[63] != x[63]);
    end else begin
      s = {1'b0, x} + {1'b0, y} + {64'b0, ci};
      r = s[63:0]; c = s[64]; v = (x[63] == y[63]) && (r[63] != x[63]);
    end
    return {c, v, (r == 64'd0), r[63], r};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, got, cnt, sent, rcvd;
    logic [31:0] prev_sum;
    logic        prev_valid, cons, acc;
    logic [31:0] q32[$];
    logic [19:0] q16[$];
    logic [67:0] q64[$];
    logic [15:0] x16, y16;
    logic [63:0] x64, y64;
    logic        ci, sb;

    vecs[0]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};

    b32.in_valid = 1'b1; b32.in_x = 32'hDEAD_BEEF; b32.in_y = 32'h1234_5678;
    b32.in_carry = 1'b1; b32.in_sub = 1'b0; b32.in_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_x = '0; b16.in_y = '0; b16.in_carry = 1'b0;
    b16.in_sub = 1'b0; b16.in_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_x = '0; b64.in_y = '0; b64.in_carry = 1'b0;
    b64.in_sub = 1'b0; b64.in_ready = 1'b1;

    // Reset for two edges with a beat offered
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", b32.out_valid, 0);
    chk("rst_sum", b32.out_sum, 0);
    chk("rst_flags", {b32.out_carry, b32.out_overflow, b32.out_zero, b32.out_negative}, 0);
    rst = 1'b0;
    b32.in_valid = 1'b0;
    tick();
    chk("rst_ready", b32.out_ready_in, 1);
    chk("rst_idle_valid", b32.out_valid, 0);

    // Single-beat directed vectors with latency check
    for (int i = 0; i < 11; i++) begin
      b32.in_x = vecs[i].x; b32.in_y = vecs[i].y;
      b32.in_carry = vecs[i].ci; b32.in_sub = vecs[i].sub;
      b32.in_valid = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      lat = 1;
      while (!b32.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_sum", i), b32.out_sum, vecs[i].s);
      chk($sformatf("v%0d_carry", i), b32.out_carry, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), b32.out_overflow, vecs[i].v);
      chk($sformatf("v%0d_zero", i), b32.out_zero, vecs[i].z);
      chk($sformatf("v%0d_neg", i), b32.out_negative, vecs[i].n);
    end
    tick();

    // Back-to-back stream of x=i, y=i
    got = 0;
    b32.in_sub = 1'b0; b32.in_carry = 1'b0; b32.in_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t < 8) begin
        b32.in_valid = 1'b1; b32.in_x = t + 1; b32.in_y = t + 1;
      end else begin
        b32.in_valid = 1'b0;
      end
      tick();
      if (b32.out_valid) begin
        chk($sformatf("stream_sum%0d", got), b32.out_sum, 2 * (got + 1));
        chk($sformatf("stream_cycle%0d", got), t + 1, got + 4);
        got++;
      end
    end
    chk("stream_count", got, 8);

    // Backpressure: in_ready low for 3 cycles while results are waiting
    sent = 0; rcvd = 0;
    for (int t = 0; t < 30; t++) begin
      b32.in_ready = !(t >= 5 && t < 8);
      b32.in_valid = (sent < 6);
      b32.in_x = (sent + 1) * 256; b32.in_y = sent + 1;
      #1;
      if (t >= 4 && t < 9)
        chk($sformatf("bp_ready_t%0d", t), b32.out_ready_in, !b32.out_valid || b32.in_ready);
      cons = b32.out_valid && b32.in_ready;
      acc  = b32.in_valid && (!b32.out_valid || b32.in_ready);
      if (cons) begin
        if (q32.size() == 0) chk("bp_spurious", 1, 0);
        else chk($sformatf("bp_sum%0d", rcvd), b32.out_sum, q32.pop_front());
        rcvd++;
      end
      prev_sum = b32.out_sum; prev_valid = b32.out_valid;
      if (acc) begin
        q32.push_back(b32.in_x + b32.in_y);
        sent++;
      end
      @(posedge clk); #1;
      if (prev_valid && !b32.in_ready) begin
        chk($sformatf("bp_hold_valid_t%0d", t), b32.out_valid, 1);
        chk($sformatf("bp_hold_sum_t%0d", t), b32.out_sum, prev_sum);
      end
    end
    chk("bp_sent", sent, 6);
    chk("bp_rcvd", rcvd, 6);
    b32.in_ready = 1'b1; b32.in_valid = 1'b0;
    tick();

    // Mid-flight reset with three beats in the pipe and a fourth offered
    for (int t = 0; t < 3; t++) begin
      b32.in_valid = 1'b1; b32.in_x = 32'h100 + t; b32.in_y = 32'h1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", b32.out_valid, 0);
    chk("mid_rst_sum", b32.out_sum, 0);
    rst = 1'b0; b32.in_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (b32.out_valid) cnt++;
    end
    chk("mid_rst_leak", cnt, 0);

    // Random sweep on the 16/4 and 64/16 instances against the reference model
    for (int t = 0; t < 50; t++) begin
      if (t < 40) begin
        x16 = 16'($urandom); y16 = 16'($urandom);
        ci = 1'($urandom); sb = 1'($urandom);
        b16.in_valid = 1'b1; b16.in_x = x16; b16.in_y = y16;
        b16.in_carry = ci; b16.in_sub = sb;
        q16.push_back(ref16(x16, y16, ci, sb));
        x64 = {$urandom, $urandom}; y64 = {$urandom, $urandom};
        if (t == 0) begin x64 = 64'h8000_0000_0000_0000; y64 = 64'h1; sb = 1'b1; end
        if (t == 1) begin x64 = '1; y64 = 64'h1; sb = 1'b0; end
        b64.in_valid = 1'b1; b64.in_x = x64; b64.in_y = y64;
        b64.in_carry = ci; b64.in_sub = sb;
        q64.push_back(ref64(x64, y64, ci, sb));
      end else begin
        b16.in_valid = 1'b0; b64.in_valid = 1'b0;
      end
      tick();
      if (b16.out_valid) begin
        if (q16.size() == 0) chk("w16_spurious", 1, 0);
        else chk($sformatf("w16_r%0d", t), {b16.out_carry, b16.out_overflow,
                 b16.out_zero, b16.out_negative, b16.out_sum}, q16.pop_front());
      end
      if (b64.out_valid) begin
        if (q64.size() == 0) chk("w64_spurious", 1, 0);
        else chk($sformatf("w64_r%0d", t), {b64.out_carry, b64.out_overflow,
                 b64.out_zero, b64.out_negative, b64.out_sum}, q64.pop_front());
      end
    end
    chk("w16_drained", q16.size(), 0);
    chk("w64_drained", q64.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
